slow_clock_ctrl: RTL and testbench

Run-time controller for the prescaler that derives the slow clock from CLOCK. Owns the 24-bit divide counter and its half-period register, and accepts new divide values over a valid/ready handshake. New values take effect only on a half-period boundary, so SLOW never glitches. Provides SLOW (square wave) and TICK (one-cycle strobe per SLOW edge) to downstream display/timing logic.

---
 rtl/slow_clock_pkg.sv | 13 +
 rtl/slow_clock_ctrl_div_counter.sv | 47 ++++
 rtl/slow_clock_ctrl.sv | 86 ++++++++
 tb/tb_slow_clock_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/slow_clock_pkg.sv
// Shared types and defaults for the slow clock prescaler controller.
package slow_clock_pkg;

    localparam int          WIDTH_DEF        = 24;
    localparam logic [23:0] DEFAULT_HALF_DEF = 24'd4_999_999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

endpackage

// File: rtl/slow_clock_ctrl_div_counter.sv
// Half-period counter: owns COUNT, the SLOW square wave and the TICK strobe.
module div_counter #(
    parameter int WIDTH = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] half_i,
    output logic             boundary_o,
    output logic             slow_o,
    output logic             tick_o
);

    logic [WIDTH-1:0] count_q;
    logic             slow_q;
    logic             tick_q;

    // Boundary is the last cycle of the current half-period.
    assign boundary_o = (count_q == half_i);
    assign slow_o     = slow_q;
    assign tick_o     = tick_q;

    // Count up to half_i, then wrap to 0 while toggling SLOW and pulsing TICK.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            slow_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else if (clear_i) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else if (run_i) begin
            if (boundary_o) begin
                count_q <= '0;
                slow_q  <= ~slow_q;
                tick_q  <= 1'b1;
            end else begin
                count_q <= count_q + 1'b1;
                tick_q  <= 1'b0;
            end
        end else begin
            tick_q <= 1'b0;
        end
    end

endmodule

// File: rtl/slow_clock_ctrl.sv
// Run-time controller for the slow clock prescaler.
// Handshake: a divide value transfers on a rising CLOCK edge where
// DIV_VALID && DIV_READY; DIV_READY is combinational from state and RESET
// and drops while a value is pending for the next half-period boundary.
module slow_clock_ctrl
    import slow_clock_pkg::*;
#(
    parameter int               WIDTH        = WIDTH_DEF,
    parameter logic [WIDTH-1:0] DEFAULT_HALF = WIDTH'(DEFAULT_HALF_DEF)
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             DIV_VALID,
    input  logic [WIDTH-1:0] DIV_VALUE,
    output logic             DIV_READY,
    output logic             SLOW,
    output logic             TICK,
    output logic [WIDTH-1:0] ACTIVE_DIV,
    output state_t           state_dbg_o
);

    state_t           state_q;
    logic [WIDTH-1:0] active_q;
    logic [WIDTH-1:0] pend_q;
    logic             xfer;
    logic             run;
    logic             clear;
    logic             boundary;

    assign DIV_READY   = !RESET && (state_q != PEND);
    assign xfer        = DIV_VALID && DIV_READY;
    assign ACTIVE_DIV  = active_q;
    assign state_dbg_o = state_q;

    // The edge that leaves IDLE keeps COUNT at 0, so counting starts in RUN.
    assign run   = ENABLE && (state_q != IDLE);
    assign clear = !ENABLE && (state_q != IDLE);

    div_counter #(.WIDTH(WIDTH)) u_div_counter (
        .clk_i      (CLOCK),
        .rst_i      (RESET),
        .run_i      (run),
        .clear_i    (clear),
        .half_i     (active_q),
        .boundary_o (boundary),
        .slow_o     (SLOW),
        .tick_o     (TICK)
    );

    // FSM: new divide values only reach active_q on an idle cycle or a boundary.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q  <= IDLE;
            active_q <= DEFAULT_HALF;
            pend_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer)   active_q <= DIV_VALUE;
                    if (ENABLE) state_q  <= RUN;
                end
                RUN: begin
                    if (!ENABLE) begin
                        // Stopping: no half-period in progress, so load directly.
                        if (xfer) active_q <= DIV_VALUE;
                        state_q <= IDLE;
                    end else if (boundary) begin
                        if (xfer) active_q <= DIV_VALUE;
                    end else if (xfer) begin
                        pend_q  <= DIV_VALUE;
                        state_q <= PEND;
                    end
                end
                PEND: begin
                    if (!ENABLE || boundary) begin
                        active_q <= pend_q;
                        state_q  <= ENABLE ? RUN : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slow_clock_ctrl.sv
// Self-checking bench for slow_clock_ctrl: directed scenarios plus random
// stimulus, all checked cycle by cycle against a behavioural model.
module tb_slow_clock_ctrl;
    import slow_clock_pkg::*;

    localparam int          W    = 24;
    localparam logic [23:0] DEFH = 24'd4_999_999;

    // ---------------- clock / reset ----------------
    logic         CLOCK = 1'b0;
    logic         RESET = 1'b1;
    logic         ENABLE = 1'b0;
    logic         DIV_VALID = 1'b0;
    logic [W-1:0] DIV_VALUE = '0;
    logic         DIV_READY;
    logic         SLOW;
    logic         TICK;
    logic [W-1:0] ACTIVE_DIV;
    state_t       state_dbg;

    always #5 CLOCK = ~CLOCK;

    slow_clock_ctrl #(.WIDTH(W), .DEFAULT_HALF(DEFH)) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .ENABLE      (ENABLE),
        .DIV_VALID   (DIV_VALID),
        .DIV_VALUE   (DIV_VALUE),
        .DIV_READY   (DIV_READY),
        .SLOW        (SLOW),
        .TICK        (TICK),
        .ACTIVE_DIV  (ACTIVE_DIV),
        .state_dbg_o (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Mode, position inside the current half-period, active and pending values.
    state_t m_mode;
    int     m_pos;
    int     m_act;
    int     m_pend;
    bit     m_slow;
    bit     m_tick;

    task automatic model_reset();
        m_mode = IDLE;
        m_pos  = 0;
        m_act  = int'(DEFH);
        m_pend = 0;
        m_slow = 0;
        m_tick = 0;
    endtask

    task automatic model_edge(input bit rst, input bit en, input bit v, input int val);
        bit xfer;
        bit last;
        xfer = v && !rst && (m_mode != PEND);
        if (rst) begin
            model_reset();
            return;
        end
        m_tick = 0;
        if (m_mode == IDLE) begin
            if (xfer) m_act = val;
            if (en) m_mode = RUN;
        end else if (!en) begin
            // Stopping discards the half-period; pending or offered value applies.
            if (m_mode == PEND) m_act = m_pend;
            else if (xfer) m_act = val;
            m_pos  = 0;
            m_mode = IDLE;
        end else begin
            last = (m_pos == m_act);
            if (last) begin
                m_pos  = 0;
                m_slow = !m_slow;
                m_tick = 1;
                if (m_mode == PEND) begin
                    m_act  = m_pend;
                    m_mode = RUN;
                end else if (xfer) begin
                    m_act = val;
                end
            end else begin
                m_pos = m_pos + 1;
                if (xfer) begin
                    m_pend = val;
                    m_mode = PEND;
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit rst, input bit en, input bit v, input int val);
        RESET     = rst;
        ENABLE    = en;
        DIV_VALID = v;
        DIV_VALUE = W'(val);
        #1;
        check_eq("div_ready", 32'(DIV_READY), 32'(!rst && (m_mode != PEND)));
        @(posedge CLOCK);
        model_edge(rst, en, v, val);
        #1;
        check_eq("slow", 32'(SLOW), 32'(m_slow));
        check_eq("tick", 32'(TICK), 32'(m_tick));
        check_eq("active_div", 32'(ACTIVE_DIV), 32'(m_act));
        check_eq("state", 32'(state_dbg), 32'(m_mode));
    endtask

    // Steps with ENABLE=1 until TICK shows; returns steps taken.
    task automatic run_until_tick(input int max_cycles, output int steps);
        bit found;
        found = 0;
        steps = 0;
        while (!found && steps < max_cycles) begin
            step(0, 1, 0, 0);
            steps++;
            if (TICK) found = 1;
        end
        check_eq("tick_seen", 32'(found), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bit slow_before;
        model_reset();

        // Reset and first post-reset values.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check_eq("reset_active", 32'(ACTIVE_DIV), 32'(DEFH));
        check_eq("reset_slow", 32'(SLOW), 32'd0);
        RESET = 1'b0;
        #1;
        check_eq("ready_after_release", 32'(DIV_READY), 32'd1);

        // IDLE load of N=3, then enable.
        step(0, 0, 1, 3);
        check_eq("idle_load", 32'(ACTIVE_DIV), 32'd3);
        step(0, 1, 0, 0);
        run_until_tick(20, n);
        check_eq("first_tick_gap", 32'(n), 32'd4);
        slow_before = SLOW;
        run_until_tick(20, n);
        check_eq("tick_gap_n3", 32'(n), 32'd4);
        run_until_tick(20, n);
        check_eq("slow_period_half", 32'(SLOW), 32'(slow_before));

        // Load 1 mid half-period: old spacing finishes, then spacing 2.
        step(0, 1, 0, 0);
        step(0, 1, 1, 1);
        check_eq("pend_state", 32'(state_dbg), 32'(PEND));
        run_until_tick(20, n);
        check_eq("old_gap_kept", 32'(n + 2), 32'd4);
        check_eq("active_after_pend", 32'(ACTIVE_DIV), 32'd1);
        run_until_tick(20, n);
        check_eq("new_gap_n1", 32'(n), 32'd2);

        // Back to N=3, then transfer 5 exactly on the boundary.
        step(0, 0, 0, 0);
        step(0, 0, 1, 3);
        step(0, 1, 0, 0);
        run_until_tick(20, n);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 5);
        check_eq("boundary_load", 32'(ACTIVE_DIV), 32'd5);
        check_eq("boundary_tick", 32'(TICK), 32'd1);
        check_eq("boundary_state", 32'(state_dbg), 32'(RUN));
        run_until_tick(20, n);
        check_eq("gap_n5", 32'(n), 32'd6);

        // ENABLE=0 while PEND holds 7.
        step(0, 1, 0, 0);
        step(0, 1, 1, 7);
        step(0, 1, 0, 0);
        slow_before = SLOW;
        step(0, 0, 0, 0);
        check_eq("disable_pend_state", 32'(state_dbg), 32'(IDLE));
        check_eq("disable_pend_active", 32'(ACTIVE_DIV), 32'd7);
        check_eq("disable_pend_slow", 32'(SLOW), 32'(slow_before));
        check_eq("disable_pend_tick", 32'(TICK), 32'd0);

        // RESET in PEND drops the pending value.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 2);
        step(1, 1, 0, 0);
        check_eq("midreset_slow", 32'(SLOW), 32'd0);
        check_eq("midreset_active", 32'(ACTIVE_DIV), 32'(DEFH));
        step(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
        check_eq("pending_lost", 32'(ACTIVE_DIV), 32'(DEFH));

        // N=0: TICK stays high.
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0);
            check_eq("n0_tick_high", 32'(TICK), 32'd1);
        end

        // Randomized traffic with small divide values.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) < 3,
                 int'($urandom_range(0, 6)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
